if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
// IF stage: owns the PC and fetches from instruction memory via a req/gnt/rvalid handshake,
// one request outstanding at most. Holds one fetched word in a 1-entry buffer and presents
// IR/PC4 to the IF/ID pipeline register. Drives IR=0 (NOP bubble) whenever no word is ready.
// Applies branch/jump/exception/eret redirects and flags misaligned fetch targets (AdEL).
// PARAMETERS
// RESET_PC  32'h0000_3000  PC loaded on reset
// PORTS
// clk            in   1   clock
// reset          in   1   synchronous, active-high
// stall_i        in   1   IF/ID not accepting this cycle (== ~IF_ID_en)
// redir_valid_i  in   1   redirect request, single-cycle pulse
// redir_pc_i     in   32  redirect target
// imem_req_o     out  1   fetch request
// imem_addr_o    out  32  fetch address (word aligned)
// imem_gnt_i     in   1   request accepted this cycle
// imem_rvalid_i  in   1   read data valid (>=1 cycle after gnt)
// imem_rdata_i   in   32  instruction word
// valid_f_o      out  1   buffer holds a deliverable entry
// ir_f_o         out  32  instruction; 32'h0 when !valid_f_o or adel_f_o
// pc_f_o         out  32  PC of the entry
// pc4_f_o        out  32  pc_f_o + 4 (mod 2^32)
// adel_f_o       out  1   entry is a misaligned-fetch fault
// BEHAVIOUR
// - Reset: pc=RESET_PC, state=IDLE, kill=0, valid=0, adel=0, ir buffer=0, pc buffer=0;
//   imem_req_o=0 in reset cycle. rvalid in IDLE/FAULT is ignored (covers stale responses).
// - consume = valid & ~stall_i & ~redir_valid_i. free = ~valid | consume.
// - States: IDLE (may issue), WAIT (one request outstanding), FAULT (fetch halted).
// - IDLE: imem_req_o = free & ~redir_valid_i, imem_addr_o = pc. On req&gnt -> WAIT.
//   Buffer is empty at every response (request only issued when free).
// - WAIT: imem_req_o=0. On rvalid: if kill -> drop word, kill<=0, -> IDLE;
//   else buffer<={rdata,pc_req}, valid<=1, pc<=pc+4, -> IDLE.
// - Timing: gnt same cycle, rvalid next cycle -> 1 instruction per 2 cycles, 2-cycle
//   first-fetch latency after reset.
// - Redirect (priority over stall, consume, response): valid<=0 (buffer flushed), pc<=redir_pc.
//   If WAIT, or IDLE with req&gnt this cycle: kill<=1, stay/enter WAIT, next rvalid dropped.
//   If rvalid arrives in the redirect cycle itself, it is dropped and no kill is set.
//   If redir_pc[1:0]!=0: no fetch; after any outstanding response drains (killed), buffer
//   <= {ir=0, pc=redir_pc, adel=1}, valid=1, -> FAULT. FAULT holds until next redirect.
// - Redirect issued while in FAULT leaves FAULT immediately (same rules as above).
// - Stall: buffer, pc and state hold; outstanding response still lands (buffer was empty).
// - Contract: controller asserts redirect only after the delay-slot instruction has been
//   consumed; this unit does not track delay slots.
// - pc arithmetic 32-bit wrap; 0xFFFF_FFFC + 4 = 0x0000_0000, no fault.
// - Outputs are registered except imem_req_o/imem_addr_o (state/pc/free decode).
// STRUCTURE
// - Shared package mips_pkg: RESET_PC default, NOP=32'h0, fetch state encoding
//   (IDLE/WAIT/FAULT), AdEL exception code.
// - Single module, no sub-module; PC register, state FSM, kill flag, 1-entry buffer inline.
// TESTING
// - Reset, gnt always 1, rvalid 1 cycle later, rdata=pc ^ 32'hA5A5_0000 -> entries at
//   pc 3000,3004,3008 every 2 cycles; pc4_f_o=3004,3008,300C; ir_f_o=0 between.
// - stall_i=1 for 5 cycles with valid entry at 3004 -> outputs frozen, imem_req_o=0;
//   release -> 3004 consumed, next req addr 3008.
// - Redirect to 0x0000_4180 while WAIT (rvalid delayed 3 cycles) -> stale word dropped,
//   valid_f_o=0, next delivered pc_f_o=4180.
// - Redirect to 0x0000_3002 -> no imem_req_o, valid_f_o=1, adel_f_o=1, ir_f_o=0,
//   pc_f_o=3002; holds in FAULT until redirect 4180 -> normal fetch at 4180.
// - Redirect and stall_i same cycle as rvalid -> redirect wins: word dropped, pc=target.
// - Assert reset while WAIT, then rvalid 1 cycle after reset -> ignored; first fetch at 3000.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline slice: the default reset PC, the
// NOP word used for pipeline bubbles, the instruction-fetch state encoding,
// the AdEL exception code and a small alignment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Exception code raised for a misaligned instruction fetch.
  localparam logic [4:0]  EXC_ADEL         = 5'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // free to issue a fetch
    WAIT  = 2'd1,  // one request outstanding
    FAULT = 2'd2   // fetch halted on a misaligned target
  } fetch_state_t;

  // True when the low address bits do not describe a word boundary.
  function automatic logic misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, fetches words over a req/gnt/rvalid
// instruction-memory handshake with at most one request in flight, and keeps
// one fetched word in a single-entry buffer feeding the IF/ID register.
// Redirects (branch/jump/exception/eret) flush the buffer and retarget the
// PC; a misaligned target produces a single AdEL fault entry and halts fetch
// until the next redirect.
//
// Ports
//   clk            in   1   clock
//   reset          in   1   synchronous, active-high reset
//   stall_i        in   1   IF/ID not accepting this cycle
//   redir_valid_i  in   1   redirect request (single-cycle pulse)
//   redir_pc_i     in   32  redirect target
//   imem_req_o     out  1   fetch request
//   imem_addr_o    out  32  fetch address (word aligned)
//   imem_gnt_i     in   1   request accepted this cycle
//   imem_rvalid_i  in   1   read data valid
//   imem_rdata_i   in   32  instruction word
//   valid_f_o      out  1   buffer holds a deliverable entry
//   ir_f_o         out  32  instruction (0 when empty or faulting)
//   pc_f_o         out  32  PC of the entry
//   pc4_f_o        out  32  pc_f_o + 4
//   adel_f_o       out  1   entry is a misaligned-fetch fault
// ---------------------------------------------------------------------------
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_f_o,
  output logic [31:0] ir_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc4_f_o,
  output logic        adel_f_o
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         kill_reg, kill_next;
  logic         valid_reg, valid_next;
  logic         adel_reg, adel_next;
  logic [31:0]  ir_reg, ir_next;
  logic [31:0]  pc_buf_reg, pc_buf_next;
  logic [31:0]  pc4_reg, pc4_next;

  logic         consume;
  logic         free;
  logic         fault_load;
  logic [31:0]  fault_pc;

  // A redirect never counts as consuming the held entry: the entry is flushed.
  assign consume = valid_reg & ~stall_i & ~redir_valid_i;
  assign free    = ~valid_reg | consume;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      kill_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      adel_reg   <= 1'b0;
      ir_reg     <= NOP;
      pc_buf_reg <= 32'h0;
      pc4_reg    <= 32'h4;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      kill_reg   <= kill_next;
      valid_reg  <= valid_next;
      adel_reg   <= adel_next;
      ir_reg     <= ir_next;
      pc_buf_reg <= pc_buf_next;
      pc4_reg    <= pc4_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    kill_next   = kill_reg;
    valid_next  = valid_reg;
    adel_next   = adel_reg;
    ir_next     = ir_reg;
    pc_buf_next = pc_buf_reg;
    pc4_next    = pc4_reg;
    imem_req_o  = 1'b0;
    imem_addr_o = {pc_reg[31:2], 2'b00};
    fault_load  = 1'b0;
    fault_pc    = pc_reg;

    // The IR is forced to NOP whenever the buffer empties so the registered
    // output already carries the bubble.
    if (consume) begin
      valid_next = 1'b0;
      ir_next    = NOP;
      adel_next  = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        // Issuing only when the buffer is (or is becoming) free guarantees
        // the response always finds an empty buffer.
        imem_req_o = free & ~redir_valid_i & ~reset;
        if (imem_req_o && imem_gnt_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_next = IDLE;
          if (kill_reg) begin
            // Stale word from before a redirect. A misaligned target that
            // was waiting for this drain now becomes the fault entry.
            kill_next = 1'b0;
            if (misaligned(pc_reg[1:0])) begin
              fault_load = 1'b1;
              fault_pc   = pc_reg;
            end
          end else begin
            valid_next  = 1'b1;
            ir_next     = imem_rdata_i;
            adel_next   = 1'b0;
            pc_buf_next = pc_reg;
            pc4_next    = pc_reg + 32'd4;
            pc_next     = pc_reg + 32'd4;
          end
        end
      end
      FAULT: begin
        // rvalid is ignored; only a redirect leaves this state.
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Redirect overrides stall, consume and any response this cycle. Requests
    // are never issued in a redirect cycle, so only WAIT can leave a response
    // in flight that must be killed.
    if (redir_valid_i) begin
      valid_next = 1'b0;
      ir_next    = NOP;
      adel_next  = 1'b0;
      pc_next    = redir_pc_i;
      kill_next  = 1'b0;
      state_next = IDLE;
      fault_load = 1'b0;
      if (state_reg == WAIT && !imem_rvalid_i) begin
        kill_next  = 1'b1;
        state_next = WAIT;
      end else if (misaligned(redir_pc_i[1:0])) begin
        fault_load = 1'b1;
        fault_pc   = redir_pc_i;
      end
    end

    if (fault_load) begin
      valid_next  = 1'b1;
      ir_next     = NOP;
      adel_next   = 1'b1;
      pc_buf_next = fault_pc;
      pc4_next    = fault_pc + 32'd4;
      state_next  = FAULT;
    end
  end

  assign valid_f_o = valid_reg;
  assign ir_f_o    = ir_reg;
  assign pc_f_o    = pc_buf_reg;
  assign pc4_f_o   = pc4_reg;
  assign adel_f_o  = adel_reg;

endmodule
